imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The parameter list SHALL be: MEM_DEPTH, 1024, instruction memory depth in 32-bit words.
REQ-002 The parameter list SHALL be: ADDR_W, 10, word-address width; MEM_DEPTH SHALL NOT exceed 2**ADDR_W.
REQ-003 The port list SHALL be: clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004 The port list SHALL be: reset  input  1  synchronous, active-high reset.
REQ-005 The port list SHALL be: load_start  input  1  single-cycle request to begin a program load.
REQ-006 The port list SHALL be: load_end  input  1  single-cycle marker for the end of the byte stream.
REQ-007 The port list SHALL be: byte_valid / byte_ready / byte_data  in / out / in  1 / 1 / 8  program byte stream; a byte transfers when valid&&ready.
REQ-008 The port list SHALL be: mem_we / mem_waddr / mem_wdata  out / out / out  1 / ADDR_W / 32  write port into instruction memory.
REQ-009 The port list SHALL be: cpu_hold  output  1  high while the CPU must not fetch.
REQ-010 The port list SHALL be: cpu_release  output  1  one-cycle pulse when the load completes.
REQ-011 The port list SHALL be: word_count / err_overflow  out / out  ADDR_W+1 / 1  words written / sticky overflow flag.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, FLUSH and DONE.
REQ-013 IDLE->LOAD on load_start; this clears word_count, the byte index, the word assembly register and err_overflow.
REQ-014 byte_ready SHALL be 1 only in LOAD.
REQ-015 Bytes SHALL assemble little-endian: byte k of a word goes to bits [8k+7:8k], k=0..3.
REQ-016 When the 4th byte is accepted in cycle N, mem_we SHALL be 1 in cycle N+1 only, with mem_waddr=word_count and the assembled word on mem_wdata; word_count SHALL then increment.
REQ-017 Back-to-back bytes SHALL be accepted every cycle with no bubble.
REQ-018 If word_count equals MEM_DEPTH when a word completes, the word SHALL be dropped (mem_we stays 0), err_overflow SHALL set, and word_count SHALL saturate at MEM_DEPTH.
REQ-019 load_end in LOAD SHALL cause LOAD->FLUSH; a byte accepted in the same cycle SHALL be included first.
REQ-020 In FLUSH, a partial word (byte index 1..3) SHALL be written once with its unfilled bytes zero; FLUSH lasts one cycle and then goes to DONE.
REQ-021 In DONE, cpu_release SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-022 cpu_hold SHALL be 1 from the cycle after load_start is accepted through the DONE cycle inclusive.
REQ-023 load_start outside IDLE SHALL be ignored, and load_end outside LOAD SHALL be ignored.
REQ-024 mem_waddr and mem_wdata SHALL be don't-care when mem_we=0, but SHALL be driven with no X.

Reset
REQ-025 On reset the FSM SHALL go to IDLE, and byte_ready, mem_we, cpu_hold, cpu_release and err_overflow SHALL be 0.
REQ-026 On reset word_count, mem_waddr and mem_wdata SHALL be 0, and the byte index and assembly register SHALL be cleared.
REQ-027 Reset during LOAD or FLUSH SHALL discard any partial word and SHALL issue no further writes; words already written remain in memory.

Configuration
REQ-028 The macro IMEM_LOADER_CHECKSUM_EN SHALL control the checksum feature.
REQ-029 With IMEM_LOADER_CHECKSUM_EN defined, a 32-bit output checksum SHALL be added: the XOR of every word written, cleared on reset and on load_start, and stable from DONE onward.
REQ-030 Without IMEM_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then load_start; send bytes 13,00,50,00 on consecutive cycles; then load_end -> one write of addr 0, data 0x00500013; cpu_release pulses once; word_count=1.
REQ-032 Send 6 bytes 01..06 with load_end on the same cycle as byte 06 -> writes of addr 0 = 0x04030201 and addr 1 = 0x00000605 (padded in FLUSH); word_count=2.
REQ-033 With MEM_DEPTH=4, send 20 bytes -> 4 writes at addr 0..3; word 5 dropped; err_overflow=1; word_count=4.
REQ-034 Assert reset after 2 bytes of word 3 -> no write for word 3; all outputs return to reset values the next cycle.
REQ-035 load_start during LOAD and load_end during IDLE -> no state change, no write, no cpu_release.
REQ-036 With IMEM_LOADER_CHECKSUM_EN defined, load words 0x00500013 and 0x00100093 -> checksum=0x00400080 at DONE.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian program byte stream into 32-bit words and
// writes them into instruction memory while holding the CPU. Define IMEM_LOADER_CHECKSUM_EN for the XOR checksum output.
module imem_loader #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [7:0]        byte_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_release,
    output logic [ADDR_W:0]   word_count,
    output logic              err_overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    logic [1:0]  state;
    logic [1:0]  byte_idx;
    logic [1:0]  idx_next;
    logic [31:0] asm_word;
    logic [31:0] asm_next;
    logic        accept;
    logic        word_done;
    logic        flush_wr;

    assign byte_ready  = (state == LOAD);
    assign cpu_hold    = (state != IDLE);
    assign cpu_release = (state == DONE);
    assign accept      = byte_valid && byte_ready;

    // Word as it stands after this cycle's byte (if any) has been merged in.
    always_comb begin
        asm_next = asm_word;
        idx_next = byte_idx;
        if (accept) begin
            asm_next[{byte_idx, 3'b000} +: 8] = byte_data;
            idx_next = byte_idx + 2'd1;
        end
    end

    assign word_done = accept && (byte_idx == 2'd3);
    // A partial word left over at load_end is issued so it is on the port during FLUSH.
    assign flush_wr  = byte_ready && load_end && (idx_next != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            byte_idx     <= 2'd0;
            asm_word     <= '0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            word_count   <= '0;
            err_overflow <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state        <= LOAD;
                        byte_idx     <= 2'd0;
                        asm_word     <= '0;
                        word_count   <= '0;
                        err_overflow <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum     <= '0;
`endif
                    end
                end
                LOAD: begin
                    byte_idx <= load_end ? 2'd0 : idx_next;
                    asm_word <= (word_done || load_end) ? '0 : asm_next;
                    if (load_end) state <= FLUSH;
                    // Words arriving once memory is full are dropped and flagged.
                    if (word_done || flush_wr) begin
                        if (word_count != DEPTH_L) begin
                            mem_we     <= 1'b1;
                            mem_waddr  <= word_count[ADDR_W-1:0];
                            mem_wdata  <= asm_next;
                            word_count <= word_count + ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            checksum   <= checksum ^ asm_next;
`endif
                        end else begin
                            err_overflow <= 1'b1;
                        end
                    end
                end
                FLUSH:   state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-stream model predicts every write,
// the LOAD/hold windows and the release pulse; a negedge process compares each cycle.
module tb_imem_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic          load_end;
    logic          byte_valid;
    logic          byte_ready;
    logic [7:0]    byte_data;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          cpu_release;
    logic [AW:0]   word_count;
    logic          err_overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    imem_loader #(.MEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_end(load_end),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .cpu_release(cpu_release),
        .word_count(word_count), .err_overflow(err_overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          at;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  bq[$];
    logic [31:0] log_data[$];
    int          log_addr[$];
    int          ld_lo = -1, ld_hi = -1, hold_lo = -1, hold_hi = -1, rel_cyc = -1;
    logic [31:0] exp_csum = '0;
    int          checks = 0, failures = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model's expectations.
    always @(negedge clk) begin
        bit we_exp;
        if (mon_en) begin
            we_exp = (exp_q.size() > 0) && (exp_q[0].at == cyc);
            chk("mem_we", mem_we, we_exp);
            if (mem_we) begin
                log_addr.push_back(int'(mem_waddr));
                log_data.push_back(mem_wdata);
            end
            if (we_exp) begin
                chk("mem_waddr", mem_waddr, exp_q[0].addr);
                chk("mem_wdata", mem_wdata, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            chk("byte_ready", byte_ready, (cyc >= ld_lo && cyc <= ld_hi));
            chk("cpu_hold", cpu_hold, (cyc >= hold_lo && cyc <= hold_hi));
            chk("cpu_release", cpu_release, (cyc == rel_cyc));
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (cyc == rel_cyc) chk("checksum_done", checksum, exp_csum);
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_byte_ready"}, byte_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_cpu_release"}, cpu_release, 0);
        chk({tag, "_err_overflow"}, err_overflow, 0);
        chk({tag, "_word_count"}, word_count, 0);
        chk({tag, "_mem_waddr"}, mem_waddr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Sends bq as one program. end_gap=0 puts load_end on the last byte; abort ends with reset instead.
    task automatic do_load(input int end_gap, input bit abort, input bit stray_start);
        int          s, e, n, nw, at;
        logic [31:0] word, cs;
        bit          full;
        wr_t         ent;
        n  = bq.size();
        nw = (n + 3) / 4;
        s  = cyc;
        e  = s + n + end_gap;
        cs = '0;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int k = 0; k < 4 && w * 4 + k < n; k++) word[8*k +: 8] = bq[w*4+k];
            full = (w * 4 + 3 < n);
            at   = full ? s + 1 + w * 4 + 3 + 1 : e + 1;
            if (w < DEPTH && !(abort && !full)) begin
                ent.addr = w; ent.data = word; ent.at = at;
                exp_q.push_back(ent);
                cs ^= word;
            end
        end
        exp_csum = cs;
        ld_lo   = s + 1;
        hold_lo = s + 1;
        if (abort) begin
            ld_hi = s + n + 1; hold_hi = s + n + 1; rel_cyc = -1;
        end else begin
            ld_hi = e; hold_hi = e + 2; rel_cyc = e + 2;
        end
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int j = 0; j < n; j++) begin
            byte_valid = 1'b1;
            byte_data  = bq[j];
            load_start = stray_start && (j == 1);
            load_end   = !abort && end_gap == 0 && j == n - 1;
            tick();
        end
        byte_valid = 1'b0; load_start = 1'b0; load_end = 1'b0; byte_data = 8'h00;
        if (abort) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check_reset_values("abort");
            ld_lo = -1; ld_hi = -1; hold_lo = -1; hold_hi = -1;
        end else begin
            if (end_gap > 0) begin
                repeat (end_gap - 1) tick();
                load_end = 1'b1;
                tick();
                load_end = 1'b0;
            end
            while (cyc < e + 2) tick();
            chk("word_count", word_count, (nw > DEPTH) ? DEPTH : nw);
            chk("err_overflow", err_overflow, (nw > DEPTH));
            tick();
        end
        chk("pending_writes", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; load_end = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single word followed by a separate load_end.
        log_data.delete(); log_addr.delete(); bq.delete();
        bq.push_back(8'h13); bq.push_back(8'h00); bq.push_back(8'h50); bq.push_back(8'h00);
        do_load(1, 0, 0);
        chk("t1_nwrites", log_data.size(), 1);
        if (log_data.size() >= 1) begin
            chk("t1_data0", log_data[0], 32'h0050_0013);
            chk("t1_addr0", log_addr[0], 0);
        end

        // Six bytes, load_end with the last: partial word padded in FLUSH.
        log_data.delete(); log_addr.delete(); bq.delete();
        for (int i = 1; i <= 6; i++) bq.push_back(8'(i));
        do_load(0, 0, 0);
        chk("t2_nwrites", log_data.size(), 2);
        if (log_data.size() >= 2) begin
            chk("t2_data0", log_data[0], 32'h0403_0201);
            chk("t2_data1", log_data[1], 32'h0000_0605);
            chk("t2_addr1", log_addr[1], 1);
        end

        // Overflow: 20 bytes into a 4-word memory.
        log_data.delete(); log_addr.delete(); bq.delete();
        for (int i = 0; i < 20; i++) bq.push_back(8'(i));
        do_load(1, 0, 0);
        chk("t3_nwrites", log_data.size(), 4);
        if (log_data.size() >= 4) begin
            chk("t3_data3", log_data[3], 32'h0F0E_0D0C);
            chk("t3_addr3", log_addr[3], 3);
        end

        // Reset after two bytes of the third word.
        log_data.delete(); log_addr.delete(); bq.delete();
        for (int i = 0; i < 10; i++) bq.push_back(8'(8'hA0 + i));
        do_load(0, 1, 0);
        chk("t4_nwrites", log_data.size(), 2);

        // load_end while idle must do nothing.
        load_end = 1'b1;
        repeat (3) tick();
        load_end = 1'b0;
        tick();
        chk("t5_idle_word_count", word_count, 0);
        chk("t5_idle_writes", log_data.size(), 2);

        // load_start during LOAD is ignored; two words 0x00500013, 0x00100093.
        log_data.delete(); log_addr.delete(); bq.delete();
        bq.push_back(8'h13); bq.push_back(8'h00); bq.push_back(8'h50); bq.push_back(8'h00);
        bq.push_back(8'h93); bq.push_back(8'h00); bq.push_back(8'h10); bq.push_back(8'h00);
        do_load(0, 0, 1);
        chk("t6_nwrites", log_data.size(), 2);
        if (log_data.size() >= 2) chk("t6_data1", log_data[1], 32'h0010_0093);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t6_checksum", checksum, 32'h0040_0080);
`endif

        repeat (2) tick();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
